pll_lock_sequencer: RTL and testbench

Consumer side of the PLL lock interface: samples the PLL's asynchronous `locked` output in the 42.241379 MHz system clock domain, qualifies it, and sequences the core reset. It also drives the PLL's `rst` input to recover from lock timeouts. Once the core is running, it generates the 7.040229 MHz CPU clock-enable as a 1-in-6 pulse. It sits between the PLL wrapper and the emulator core in the top level.

---
 rtl/pll_lock_sequencer.sv | 126 ++++++++++++
 tb/tb_pll_lock_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// Qualifies the asynchronous PLL lock, sequences core reset and PLL re-reset, and divides the CPU clock-enable.
// Outputs registered from next state; lock-to-release is 2 sync + LOCK_STABLE_CYCLES edges; no backpressure.
module pll_lock_sequencer #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int PLL_RST_CYCLES     = 16,
    parameter int CE_DIV             = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       ce,
    output logic       running,
    output logic [7:0] lost_cnt
);

    localparam int MAX_AB  = (LOCK_TIMEOUT > LOCK_STABLE_CYCLES) ? LOCK_TIMEOUT : LOCK_STABLE_CYCLES;
    localparam int MAX_CNT = (MAX_AB > PLL_RST_CYCLES) ? MAX_AB : PLL_RST_CYCLES;
    localparam int CW      = $clog2(MAX_CNT);
    localparam int DW      = $clog2(CE_DIV);

    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] PRST_LAST    = CW'(PLL_RST_CYCLES - 1);
    localparam logic [DW-1:0] DIV_LAST     = DW'(CE_DIV - 1);

    typedef enum logic [1:0] {ST_WAIT, ST_STABLE, ST_RUN, ST_PLLRST} state_t;

    logic          q1;
    logic          q2;
    logic          locked_s;
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [DW-1:0] div;
    logic [DW-1:0] div_nxt;
    logic [7:0]    lost_nxt;

    assign locked_s = q2;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        div_nxt   = div;
        lost_nxt  = lost_cnt;
        case (state)
            ST_WAIT: begin
                if (locked_s) begin
                    state_nxt = ST_STABLE;
                    cnt_nxt   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_nxt = ST_PLLRST;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            ST_STABLE: begin
                // Any dropout during qualification restarts from WAIT, not a loss.
                if (!locked_s) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = ST_RUN;
                    div_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = '0;
                    if (lost_cnt != 8'hFF) begin
                        lost_nxt = lost_cnt + 8'd1;
                    end
                end else begin
                    div_nxt = (div == DIV_LAST) ? '0 : div + DW'(1);
                end
            end
            ST_PLLRST: begin
                // Lock status is deliberately ignored while the PLL is held in reset.
                if (cnt == PRST_LAST) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = ST_WAIT;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q1        <= 1'b0;
            q2        <= 1'b0;
            state     <= ST_WAIT;
            cnt       <= '0;
            div       <= '0;
            lost_cnt  <= 8'd0;
            sys_reset <= 1'b1;
            running   <= 1'b0;
            pll_rst   <= 1'b0;
            ce        <= 1'b0;
        end else begin
            q1        <= pll_locked;
            q2        <= q1;
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            div       <= div_nxt;
            lost_cnt  <= lost_nxt;
            sys_reset <= (state_nxt != ST_RUN);
            running   <= (state_nxt == ST_RUN);
            pll_rst   <= (state_nxt == ST_PLLRST);
            ce        <= (state_nxt == ST_RUN) && (div_nxt == DIV_LAST);
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: edge-numbered directed tables, corner sequences and random lock traffic vs. a model.
module tb_pll_lock_sequencer;

    localparam int LSC = 8;
    localparam int LT  = 32;
    localparam int PRC = 4;
    localparam int CED = 6;

    localparam int M_WAIT   = 0;
    localparam int M_STABLE = 1;
    localparam int M_RUN    = 2;
    localparam int M_PLLRST = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_rst;
    logic       sys_reset;
    logic       ce;
    logic       running;
    logic [7:0] lost_cnt;

    pll_lock_sequencer #(
        .LOCK_STABLE_CYCLES(LSC),
        .LOCK_TIMEOUT      (LT),
        .PLL_RST_CYCLES    (PRC),
        .CE_DIV            (CED)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pll_locked(pll_locked),
        .pll_rst   (pll_rst),
        .sys_reset (sys_reset),
        .ce        (ce),
        .running   (running),
        .lost_cnt  (lost_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int ph;
        int e;
        int sr;
        int run;
        int ce;
        int prst;
        int lost;
    } vec_t;
    vec_t tbl[$];

    // Behavioural model: mode plus elapsed-edge counts; lock seen two edges late.
    int   m_mode;
    int   m_elapsed;
    int   m_age;
    int   m_lost;
    logic hist[2];
    int   edge_no;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d, t=%0t)", name, act, exp, edge_no, $time);
        end
    endtask

    task automatic model_reset();
        m_mode    = M_WAIT;
        m_elapsed = 0;
        m_age     = 0;
        m_lost    = 0;
        hist[0]   = 1'b0;
        hist[1]   = 1'b0;
        edge_no   = 0;
    endtask

    task automatic model_edge(input logic pl);
        logic ls;
        ls      = hist[1];
        hist[1] = hist[0];
        hist[0] = pl;
        case (m_mode)
            M_WAIT: begin
                if (ls) begin
                    m_mode = M_STABLE; m_elapsed = 0;
                end else begin
                    m_elapsed++;
                    if (m_elapsed == LT) begin m_mode = M_PLLRST; m_elapsed = 0; end
                end
            end
            M_STABLE: begin
                if (!ls) begin
                    m_mode = M_WAIT; m_elapsed = 0;
                end else begin
                    m_elapsed++;
                    if (m_elapsed == LSC) begin m_mode = M_RUN; m_age = 0; end
                end
            end
            M_RUN: begin
                if (!ls) begin
                    m_mode = M_WAIT; m_elapsed = 0;
                    m_lost = (m_lost < 255) ? m_lost + 1 : 255;
                end else begin
                    m_age++;
                end
            end
            default: begin
                m_elapsed++;
                if (m_elapsed == PRC) begin m_mode = M_WAIT; m_elapsed = 0; end
            end
        endcase
    endtask

    task automatic step(input logic pl);
        pll_locked = pl;
        @(posedge clk);
        #1;
        edge_no++;
        model_edge(pl);
        chk("sys_reset", int'(sys_reset), (m_mode != M_RUN) ? 1 : 0);
        chk("running",   int'(running),   (m_mode == M_RUN) ? 1 : 0);
        chk("pll_rst",   int'(pll_rst),   (m_mode == M_PLLRST) ? 1 : 0);
        chk("ce",        int'(ce),        (m_mode == M_RUN && (m_age % CED) == CED - 1) ? 1 : 0);
        chk("lost_cnt",  int'(lost_cnt),  m_lost);
    endtask

    task automatic check_table(input int ph);
        foreach (tbl[i]) begin
            if (tbl[i].ph == ph && tbl[i].e == edge_no) begin
                chk($sformatf("tbl%0d_e%0d_sys_reset", ph, edge_no), int'(sys_reset), tbl[i].sr);
                chk($sformatf("tbl%0d_e%0d_running", ph, edge_no),   int'(running),   tbl[i].run);
                chk($sformatf("tbl%0d_e%0d_ce", ph, edge_no),        int'(ce),        tbl[i].ce);
                chk($sformatf("tbl%0d_e%0d_pll_rst", ph, edge_no),   int'(pll_rst),   tbl[i].prst);
                chk($sformatf("tbl%0d_e%0d_lost_cnt", ph, edge_no),  int'(lost_cnt),  tbl[i].lost);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_sys_reset"}, int'(sys_reset), 1);
        chk({tag, "_running"},   int'(running),   0);
        chk({tag, "_pll_rst"},   int'(pll_rst),   0);
        chk({tag, "_ce"},        int'(ce),        0);
        chk({tag, "_lost_cnt"},  int'(lost_cnt),  0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pll_locked = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Raise rst between clock edges and look at the outputs before any edge arrives.
    task automatic async_rst_check(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs(tag);
    endtask

    initial begin
        logic level;
        int   burst;

        // Phase 0: lock, first ce pulses, loss, relock.
        tbl.push_back('{0,  9, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 19, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 20, 0, 1, 0, 0, 0});
        tbl.push_back('{0, 24, 0, 1, 0, 0, 0});
        tbl.push_back('{0, 25, 0, 1, 1, 0, 0});
        tbl.push_back('{0, 26, 0, 1, 0, 0, 0});
        tbl.push_back('{0, 31, 0, 1, 1, 0, 0});
        tbl.push_back('{0, 37, 0, 1, 1, 0, 0});
        tbl.push_back('{0, 51, 0, 1, 0, 0, 0});
        tbl.push_back('{0, 52, 1, 0, 0, 0, 1});
        tbl.push_back('{0, 62, 1, 0, 0, 0, 1});
        tbl.push_back('{0, 63, 0, 1, 0, 0, 1});
        tbl.push_back('{0, 68, 0, 1, 1, 0, 1});
        // Phase 1: timeout with the lock held low.
        tbl.push_back('{1, 31, 1, 0, 0, 0, 0});
        tbl.push_back('{1, 32, 1, 0, 0, 1, 0});
        tbl.push_back('{1, 35, 1, 0, 0, 1, 0});
        tbl.push_back('{1, 36, 1, 0, 0, 0, 0});
        tbl.push_back('{1, 67, 1, 0, 0, 0, 0});
        tbl.push_back('{1, 68, 1, 0, 0, 1, 0});
        tbl.push_back('{1, 70, 1, 0, 0, 1, 0});
        // Phase 2: one-cycle glitch during qualification.
        tbl.push_back('{2, 20, 1, 0, 0, 0, 0});
        tbl.push_back('{2, 26, 1, 0, 0, 0, 0});
        tbl.push_back('{2, 27, 0, 1, 0, 0, 0});
        tbl.push_back('{2, 32, 0, 1, 1, 0, 0});

        do_reset();
        for (int e = 1; e <= 70; e++) begin
            step(((e >= 10 && e < 50) || e >= 53) ? 1'b1 : 1'b0);
            check_table(0);
        end

        do_reset();
        for (int e = 1; e <= 70; e++) begin
            step(1'b0);
            check_table(1);
        end
        async_rst_check("async_pllrst");

        do_reset();
        for (int e = 1; e <= 30; e++) begin
            step((e >= 10 && e != 16) ? 1'b1 : 1'b0);
            check_table(2);
        end

        // Repeated loss/relock until the loss counter pins at its maximum.
        do_reset();
        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < 12; k++) step(1'b1);
            for (int k = 0; k < 3; k++) step(1'b0);
        end
        chk("lost_saturated", int'(lost_cnt), 255);
        for (int k = 0; k < 14; k++) step(1'b1);
        chk("run_before_async", int'(running), 1);
        async_rst_check("async_run");

        do_reset();
        level = 1'b0;
        burst = 0;
        for (int e = 0; e < 2000; e++) begin
            if (burst == 0) begin
                level = ~level;
                burst = $urandom_range(1, 45);
            end
            burst--;
            step(level);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
